// File: rtl/led7seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_pkg
// Brief    : Shared types and constants for the 7-segment scan block.
// Revision : 1.0
// ============================================================================
package led7seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Largest value representable on n decimal digits.
    function automatic int pow10_minus1(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led7seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_scan_if
// Brief    : Timer-side load bus and decoder-side digit outputs.
// Revision : 1.0
// ============================================================================
interface led7seg_scan_if #(
    parameter int NUM_DIGITS = 2,
    parameter int BIN_W      = 7
);
    logic                  load;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  overflow;
    logic [3:0]            bcd_out;
    logic                  seg_en;
    logic [NUM_DIGITS-1:0] digit_sel;

    modport master (
        output load, bin_in,
        input  busy, overflow, bcd_out, seg_en, digit_sel
    );

    modport slave (
        input  load, bin_in,
        output busy, overflow, bcd_out, seg_en, digit_sel
    );
endinterface
`default_nettype wire

// File: rtl/led7seg_scan_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential shift-add-3 binary to BCD converter with its FSM.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq
    import led7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int BIN_W      = 7
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     load,
    input  wire [BIN_W-1:0]         bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int         c_BCD_W  = 4 * NUM_DIGITS;
    localparam int         c_SR_W   = c_BCD_W + BIN_W;
    localparam int         c_CW     = $clog2(BIN_W + 1);
    localparam logic [1:0] c_IDLE   = ST_IDLE;
    localparam logic [1:0] c_CONV   = ST_CONV;
    localparam logic [1:0] c_COMMIT = ST_COMMIT;

    logic [1:0]        r_state;
    logic [c_SR_W-1:0] r_sr;
    logic [c_SR_W-1:0] w_adj;
    logic [c_CW-1:0]   r_cnt;
    logic              r_busy;

    // Nibbles beyond NUM_DIGITS are dropped; overflowed values are replaced
    // by nines downstream, so the truncated upper digits never matter.
    always_comb begin
        w_adj = r_sr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_sr[BIN_W+4*d +: 4] >= 4'd5)
                w_adj[BIN_W+4*d +: 4] = r_sr[BIN_W+4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (load) begin
                        r_sr    <= {{c_BCD_W{1'b0}}, bin_in};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_CONV;
                    end
                end
                c_CONV: begin
                    r_sr  <= {w_adj[c_SR_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(BIN_W - 1))
                        r_state <= c_COMMIT;
                end
                c_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = (r_state == c_COMMIT);
    assign bcd  = r_sr[c_SR_W-1 -: c_BCD_W];

endmodule
`default_nettype wire

// File: rtl/led7seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_scan
// Brief    : Double-buffered BCD display with multiplexed digit scanning.
// Revision : 1.0
// ============================================================================
module led7seg_scan
    import led7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int BIN_W      = 7,
    parameter int SCAN_DIV   = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  wire          clk,
    input  wire          rst_n,
    led7seg_scan_if.slave bus
);
    localparam int c_LIMIT = pow10_minus1(NUM_DIGITS);
    localparam int c_PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    w_busy;
    logic                    w_done;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    w_accept;
    logic                    w_tc;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_zero_above;
    logic                    w_blank;
    logic [3:0]              w_nib;

    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_overflow;
    logic [c_PW-1:0]         r_presc;
    logic [c_IW-1:0]         r_idx;
    logic [3:0]              r_bcd_out;
    logic                    r_seg_en;
    logic [NUM_DIGITS-1:0]   r_digit_sel;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.load),
        .bin_in (bus.bin_in),
        .busy   (w_busy),
        .done   (w_done),
        .bcd    (w_bcd)
    );

    // The converter only accepts in IDLE, which is exactly when busy is low.
    assign w_accept = bus.load & ~w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_disp     <= '0;
        end else begin
            if (w_accept)
                r_overflow <= (int'(bus.bin_in) > c_LIMIT);
            if (w_done)
                r_disp <= r_overflow ? {NUM_DIGITS{4'h9}} : w_bcd;
        end
    end

    assign w_tc = (r_presc == c_PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // w_lz[d] is set when digit d and every digit above it are zero.
    always_comb begin
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_zero_above = w_zero_above & (r_disp[4*d +: 4] == 4'd0);
            w_lz[d]      = w_zero_above;
        end
    end

    assign w_nib   = r_disp[4*r_idx +: 4];
    assign w_blank = (LZ_BLANK != 0) && (r_idx != '0) && w_lz[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_out   <= 4'h0;
            r_seg_en    <= 1'b0;
            r_digit_sel <= '1;
        end else begin
            r_digit_sel <= ~(NUM_DIGITS'(1) << r_idx);
            r_bcd_out   <= w_blank ? BCD_BLANK : w_nib;
            r_seg_en    <= ~w_blank;
        end
    end

    assign bus.busy      = w_busy;
    assign bus.overflow  = r_overflow;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.seg_en    = r_seg_en;
    assign bus.digit_sel = r_digit_sel;

endmodule
`default_nettype wire
